// File: rtl/axi_buf_pkg.sv
// rtl/axi_buf_pkg.sv - shared AXI buffer types: B response encodings and B entry layout
// Reused by the AW/W/B/R slave-side buffers.
package axi_buf_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  localparam int B_ID_WIDTH   = 16;
  localparam int B_USER_WIDTH = 10;

  typedef struct packed {
    logic [1:0]              resp;
    logic [B_ID_WIDTH-1:0]   id;
    logic [B_USER_WIDTH-1:0] user;
  } b_entry_t;

  // SLVERR and DECERR both carry resp[1]=1.
  function automatic logic is_err_resp(input logic [1:0] resp);
    return resp[1];
  endfunction

endpackage

// File: rtl/slave_buf_fifo.sv
// rtl/slave_buf_fifo.sv - generic first-word fall-through FIFO with wrap-bit pointers
// Input ready is registered so it never follows out_ready_i combinationally.
module slave_buf_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     in_valid_i,
  input  logic [WIDTH-1:0]         in_data_i,
  output logic                     in_ready_o,
  output logic                     out_valid_o,
  output logic [WIDTH-1:0]         out_data_o,
  input  logic                     out_ready_i,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             ready_q;
  logic             empty, push, pop, full_d;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign push  = in_valid_i & ready_q;
  assign pop   = ~empty & out_ready_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    full_d   = (wr_ptr_d[IDX_W-1:0] == rd_ptr_d[IDX_W-1:0]) &&
               (wr_ptr_d[IDX_W] != rd_ptr_d[IDX_W]);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ready_q  <= ~full_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q[IDX_W-1:0]] <= in_data_i;
    end
  end

  // Storage is not reset; the head is masked to zero while empty instead.
  assign out_data_o  = empty ? '0 : mem_q[rd_ptr_q[IDX_W-1:0]];
  assign out_valid_o = ~empty;
  assign in_ready_o  = ready_q;
  assign count_o     = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/slave_b_buffer_i.sv
// rtl/slave_b_buffer_i.sv - AXI4 B-channel return buffer with saturating error counter
// Queues downstream write responses in order and replays them upstream.
module slave_b_buffer_i
  import axi_buf_pkg::*;
#(
  parameter int ID_WIDTH   = 16,
  parameter int USER_WIDTH = 10,
  parameter int BUFF_DEPTH = 4,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        master_valid_i,
  input  logic [1:0]                  master_resp_i,
  input  logic [ID_WIDTH-1:0]         master_id_i,
  input  logic [USER_WIDTH-1:0]       master_user_i,
  output logic                        master_ready_o,
  output logic                        slave_valid_o,
  output logic [1:0]                  slave_resp_o,
  output logic [ID_WIDTH-1:0]         slave_id_o,
  output logic [USER_WIDTH-1:0]       slave_user_o,
  input  logic                        slave_ready_i,
  output logic [$clog2(BUFF_DEPTH):0] count_o,
  output logic [ERR_CNT_W-1:0]        err_count_o,
  input  logic                        err_clr_i
);

  localparam int ENTRY_W = 2 + ID_WIDTH + USER_WIDTH;

  logic [ENTRY_W-1:0]   in_entry, out_entry;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic                 push_fire;

  assign in_entry  = {master_resp_i, master_id_i, master_user_i};
  assign push_fire = master_valid_i & master_ready_o;

  slave_buf_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (BUFF_DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (master_valid_i),
    .in_data_i   (in_entry),
    .in_ready_o  (master_ready_o),
    .out_valid_o (slave_valid_o),
    .out_data_o  (out_entry),
    .out_ready_i (slave_ready_i),
    .count_o     (count_o)
  );

  assign {slave_resp_o, slave_id_o, slave_user_o} = out_entry;

  // Clear wins over a same-cycle error push.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_clr_i) begin
      err_cnt_d = '0;
    end else if (push_fire && is_err_resp(master_resp_i) && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_count_o = err_cnt_q;

endmodule

// File: tb/tb_slave_b_buffer_i.sv
// tb/tb_slave_b_buffer_i.sv - scoreboard bench for slave_b_buffer_i
// Negedge monitor keeps a queue model of the buffer and checks every cycle.
module tb_slave_b_buffer_i;
  import axi_buf_pkg::*;

  localparam int DEPTH = 4;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        master_valid_i = 1'b0;
  logic [1:0]  master_resp_i = 2'b00;
  logic [15:0] master_id_i = '0;
  logic [9:0]  master_user_i = '0;
  logic        master_ready_o;
  logic        slave_valid_o;
  logic [1:0]  slave_resp_o;
  logic [15:0] slave_id_o;
  logic [9:0]  slave_user_o;
  logic        slave_ready_i = 1'b0;
  logic [2:0]  count_o;
  logic [7:0]  err_count_o;
  logic        err_clr_i = 1'b0;

  int checks = 0;
  int failures = 0;

  slave_b_buffer_i #(
    .ID_WIDTH   (16),
    .USER_WIDTH (10),
    .BUFF_DEPTH (DEPTH),
    .ERR_CNT_W  (8)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .master_valid_i (master_valid_i),
    .master_resp_i  (master_resp_i),
    .master_id_i    (master_id_i),
    .master_user_i  (master_user_i),
    .master_ready_o (master_ready_o),
    .slave_valid_o  (slave_valid_o),
    .slave_resp_o   (slave_resp_o),
    .slave_id_o     (slave_id_o),
    .slave_user_o   (slave_user_o),
    .slave_ready_i  (slave_ready_i),
    .count_o        (count_o),
    .err_count_o    (err_count_o),
    .err_clr_i      (err_clr_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of expected entries, registered ready, error count.
  b_entry_t exp_q[$];
  bit       ready_m = 1'b0;
  int       err_m = 0;
  bit       zero_head_m = 1'b1;

  initial begin
    @(posedge clk_i);
    forever begin
      @(negedge clk_i);
      chk("slave_valid", 32'(slave_valid_o), 32'(exp_q.size() != 0));
      chk("count", 32'(count_o), 32'(exp_q.size()));
      chk("master_ready", 32'(master_ready_o), 32'(ready_m));
      chk("err_count", 32'(err_count_o), 32'(err_m));
      if (exp_q.size() != 0)
        chk("head_entry", 32'({slave_resp_o, slave_id_o, slave_user_o}), 32'(exp_q[0]));
      else if (zero_head_m)
        chk("reset_head_zero", 32'({slave_resp_o, slave_id_o, slave_user_o}), 32'd0);

      // Advance the model to the state after the coming posedge.
      if (rst_i) begin
        exp_q.delete();
        ready_m = 1'b0;
        err_m = 0;
        zero_head_m = 1'b1;
      end else begin
        bit do_push;
        do_push = master_valid_i && ready_m;
        if (slave_ready_i && exp_q.size() != 0) void'(exp_q.pop_front());
        if (do_push) begin
          exp_q.push_back('{resp: master_resp_i, id: master_id_i, user: master_user_i});
          zero_head_m = 1'b0;
        end
        if (err_clr_i) err_m = 0;
        else if (do_push && master_resp_i[1] && err_m < 255) err_m++;
        ready_m = (exp_q.size() < DEPTH);
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_one(input logic [1:0] resp, input logic [15:0] id, input logic [9:0] user);
    bit ok = 1'b0;
    master_valid_i = 1'b1;
    master_resp_i  = resp;
    master_id_i    = id;
    master_user_i  = user;
    for (int k = 0; k < 50; k++) begin
      bit r;
      r = master_ready_o;
      step();
      if (r) begin
        ok = 1'b1;
        break;
      end
    end
    master_valid_i = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL push_timeout actual=0 expected=1 id=%0h", id);
    end
  endtask

  initial begin
    // 1: reset with valid asserted
    rst_i = 1'b1;
    master_valid_i = 1'b1;
    master_id_i = 16'hDEAD;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_ready", 32'(master_ready_o), 32'd0);
      chk("rst_valid", 32'(slave_valid_o), 32'd0);
    end
    master_valid_i = 1'b0;
    rst_i = 1'b0;
    step();
    chk("ready_after_release", 32'(master_ready_o), 32'd1);

    // 2: single OKAY push, popped immediately
    slave_ready_i = 1'b1;
    push_one(RESP_OKAY, 16'h00A5, 10'h03F);
    chk("single_valid", 32'(slave_valid_o), 32'd1);
    chk("single_id", 32'(slave_id_o), 32'h00A5);
    chk("single_user", 32'(slave_user_o), 32'h03F);
    step();
    chk("single_count_after_pop", 32'(count_o), 32'd0);

    // 3: fill while blocked, 5th held off
    slave_ready_i = 1'b0;
    for (int i = 1; i <= 4; i++) push_one(RESP_OKAY, 16'(i), 10'(i));
    master_valid_i = 1'b1;
    master_id_i = 16'd5;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("full_count", 32'(count_o), 32'd4);
      chk("full_ready", 32'(master_ready_o), 32'd0);
    end
    master_valid_i = 1'b0;
    slave_ready_i = 1'b1;
    step();
    chk("ready_after_first_pop", 32'(master_ready_o), 32'd1);
    for (int i = 0; i < 5; i++) step();

    // 4: steady push+pop at occupancy 2
    slave_ready_i = 1'b0;
    push_one(RESP_EXOKAY, 16'h0100, 10'h100);
    push_one(RESP_EXOKAY, 16'h0101, 10'h101);
    slave_ready_i = 1'b1;
    master_valid_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      master_id_i = 16'h0102 + 16'(i);
      master_user_i = 10'(i);
      step();
      chk("steady_count", 32'(count_o), 32'd2);
    end
    master_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) step();

    // 5: error counting, saturation, clear priority
    err_clr_i = 1'b1;
    step();
    err_clr_i = 1'b0;
    push_one(RESP_SLVERR, 16'h0201, 10'h1);
    push_one(RESP_DECERR, 16'h0202, 10'h2);
    push_one(RESP_OKAY, 16'h0203, 10'h3);
    push_one(RESP_EXOKAY, 16'h0204, 10'h4);
    chk("err_count_mix", 32'(err_count_o), 32'd2);
    for (int i = 0; i < 300; i++) push_one(RESP_SLVERR, 16'(i), 10'(i));
    chk("err_saturate", 32'(err_count_o), 32'd255);
    err_clr_i = 1'b1;
    push_one(RESP_DECERR, 16'h0300, 10'h0);
    err_clr_i = 1'b0;
    chk("err_clear_priority", 32'(err_count_o), 32'd0);
    for (int i = 0; i < 4; i++) step();

    // 6: reset with entries queued
    slave_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) push_one(RESP_SLVERR, 16'h0400 + 16'(i), 10'(i));
    rst_i = 1'b1;
    step();
    chk("midrst_valid", 32'(slave_valid_o), 32'd0);
    chk("midrst_count", 32'(count_o), 32'd0);
    rst_i = 1'b0;
    slave_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) step();

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      master_valid_i = 1'($urandom_range(0, 1));
      master_resp_i  = 2'($urandom_range(0, 3));
      master_id_i    = 16'($urandom);
      master_user_i  = 10'($urandom);
      slave_ready_i  = ($urandom_range(0, 3) != 0);
      err_clr_i      = ($urandom_range(0, 39) == 0);
      rst_i          = ($urandom_range(0, 199) == 0);
      step();
    end
    master_valid_i = 1'b0;
    err_clr_i = 1'b0;
    rst_i = 1'b0;
    slave_ready_i = 1'b1;
    for (int i = 0; i < 10; i++) step();
    chk("drained_count", 32'(count_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
